// File: rtl/mul_issue_ctrl_if.sv
// Issue, multiplier and writeback signals of the multiply issue/writeback stage.
// MUL_PERF_CNT_EN adds the perf counter outputs.
interface mul_issue_ctrl_if #(
    parameter int XLEN       = 32,
    parameter int ROB_TAG_W  = 4,
    parameter int REG_ADDR_W = 5
);
    logic                  flush_i;
    logic                  issue_valid_i;
    logic                  issue_ready_o;
    logic [XLEN-1:0]       op_A_i;
    logic [XLEN-1:0]       op_B_i;
    logic [1:0]            ops_i;
    logic [REG_ADDR_W-1:0] rd_i;
    logic [ROB_TAG_W-1:0]  tag_i;
    logic [XLEN-1:0]       mul_A_o;
    logic [XLEN-1:0]       mul_B_o;
    logic [1:0]            mul_ops_o;
    logic                  mul_clk_en_o;
    logic [XLEN-1:0]       mul_result_i;
    logic                  wb_valid_o;
    logic                  wb_ready_i;
    logic [XLEN-1:0]       wb_result_o;
    logic [REG_ADDR_W-1:0] wb_rd_o;
    logic [ROB_TAG_W-1:0]  wb_tag_o;
    logic                  busy_o;
`ifdef MUL_PERF_CNT_EN
    logic [31:0]           perf_issued_o;
    logic [31:0]           perf_stall_o;
`endif

    modport slave (
        input  flush_i, issue_valid_i, op_A_i, op_B_i, ops_i, rd_i, tag_i,
        input  mul_result_i, wb_ready_i,
        output issue_ready_o, mul_A_o, mul_B_o, mul_ops_o, mul_clk_en_o,
        output wb_valid_o, wb_result_o, wb_rd_o, wb_tag_o, busy_o
`ifdef MUL_PERF_CNT_EN
        , output perf_issued_o, perf_stall_o
`endif
    );

    modport master (
        output flush_i, issue_valid_i, op_A_i, op_B_i, ops_i, rd_i, tag_i,
        output mul_result_i, wb_ready_i,
        input  issue_ready_o, mul_A_o, mul_B_o, mul_ops_o, mul_clk_en_o,
        input  wb_valid_o, wb_result_o, wb_rd_o, wb_tag_o, busy_o
`ifdef MUL_PERF_CNT_EN
        , input perf_issued_o, perf_stall_o
`endif
    );
endinterface

// File: rtl/mul_issue_ctrl.sv
// Issue/writeback control around a LATENCY-deep pipelined multiplier; results appear LATENCY edges after issue.
// A held writeback result freezes the whole pipe (and the multiplier via CE); MUL_PERF_CNT_EN adds perf counters.
module mul_issue_ctrl #(
    parameter int XLEN       = 32,
    parameter int LATENCY    = 3,
    parameter int ROB_TAG_W  = 4,
    parameter int REG_ADDR_W = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    mul_issue_ctrl_if.slave    bus
);
    typedef struct packed {
        logic                  vld;
        logic [1:0]            op;
        logic [REG_ADDR_W-1:0] rd;
        logic [ROB_TAG_W-1:0]  tag;
    } stage_t;

    stage_t r_stage [LATENCY];
    logic   w_adv;
    logic   w_issue_rdy;
    logic   w_accept;
    logic   w_busy;
    stage_t w_out;

    assign w_out       = r_stage[LATENCY-1];
    // Only a valid result waiting on writeback can stall; a flush always moves.
    assign w_adv       = !(w_out.vld && !bus.wb_ready_i) || bus.flush_i;
    assign w_issue_rdy = w_adv && !bus.flush_i;
    assign w_accept    = bus.issue_valid_i && w_issue_rdy;

    assign bus.issue_ready_o = w_issue_rdy;
    assign bus.mul_clk_en_o  = w_adv;
    assign bus.mul_A_o       = bus.op_A_i;
    assign bus.mul_B_o       = bus.op_B_i;
    assign bus.mul_ops_o     = w_out.op;
    assign bus.wb_valid_o    = w_out.vld;
    assign bus.wb_result_o   = w_out.vld ? bus.mul_result_i : '0;
    assign bus.wb_rd_o       = w_out.rd;
    assign bus.wb_tag_o      = w_out.tag;
    assign bus.busy_o        = w_busy;

    always_comb begin
        w_busy = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            w_busy = w_busy | r_stage[i].vld;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_stage[i] <= '0;
            end
        end else if (bus.flush_i) begin
            // Sideband fields stay put; only the valid bits die.
            for (int i = 0; i < LATENCY; i++) begin
                r_stage[i].vld <= 1'b0;
            end
        end else if (w_adv) begin
            r_stage[0].vld <= w_accept;
            r_stage[0].op  <= bus.ops_i;
            r_stage[0].rd  <= bus.rd_i;
            r_stage[0].tag <= bus.tag_i;
            for (int i = 1; i < LATENCY; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

`ifdef MUL_PERF_CNT_EN
    logic [31:0] r_perf_issued;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_perf_issued <= '0;
            r_perf_stall  <= '0;
        end else begin
            if (w_accept) begin
                r_perf_issued <= r_perf_issued + 32'd1;
            end
            if (!w_adv && bus.issue_valid_i) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign bus.perf_issued_o = r_perf_issued;
    assign bus.perf_stall_o  = r_perf_stall;
`endif
endmodule
